grid_step_sequencer: RTL and testbench

//  Game-step controller for the 16x16 Tetris playfield; sole owner of the row-wide grid RAM port.

---
 rtl/grid_step_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_grid_step_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_step_sequencer.sv
// Single-clock game-step FSM for the Tetris playfield; sole owner of the row-wide grid RAM port.
// Optional score output is enabled by defining SCORE_EN.
module grid_step_sequencer #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int SPAWN_X = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            move_left,
    input  logic            move_right,
    input  logic [7:0]      piece_mask,
    output logic [3:0]      rd_addr,
    input  logic [COLS-1:0] rd_data,
    output logic            wr_en,
    output logic [3:0]      wr_addr,
    output logic [COLS-1:0] wr_data,
    output logic [4:0]      piece_x,
    output logic [4:0]      piece_y,
    output logic            busy,
    output logic            locked,
    output logic [1:0]      lines_cleared,
    output logic            game_over
`ifdef SCORE_EN
    ,
    output logic [15:0]     score
`endif
);

    typedef enum logic [3:0] {
        S_INIT, S_SPAWN, S_SP_RD, S_SP_CHK, S_IDLE, S_HM_RD, S_HM_CHK,
        S_VC_CHK, S_LOCK_A, S_LOCK_B, S_CP_RD, S_CP_EV, S_CLR, S_OVER
    } state_t;

    localparam logic [COLS-1:0] FULL_ROW = '1;
    localparam logic [4:0]      SPAWN_X5 = 5'(SPAWN_X);
    localparam logic [3:0]      LAST_ROW = 4'(ROWS - 1);

    state_t            state_q, state_d;
    logic [4:0]        x_q, x_d, y_q, y_d;
    logic signed [5:0] cx_q, cx_d;
    logic [7:0]        mask_q, mask_d;
    logic [COLS-1:0]   ra_q, ra_d, rb_q, rb_d;
    logic [3:0]        rp_q, rp_d;
    logic [4:0]        wp_q, wp_d;
    logic [1:0]        clr_q, clr_d, clr_nx;
    logic [1:0]        lines_q, lines_d;
    logic              locked_q, locked_d;
    logic              over_q, over_d;
    logic              wr_en_raw;
`ifdef SCORE_EN
    logic [15:0]       score_q, score_d;
    logic [16:0]       score_sum;
`endif

    // Shift is done COLS+4 wide so bits pushed past the right wall are seen, not dropped.
    function automatic logic [COLS-1:0] place(input logic [3:0] bits, input logic [4:0] col);
        logic [COLS+3:0] wide;
        wide = {{COLS{1'b0}}, bits} << col;
        return wide[COLS-1:0];
    endfunction

    // Bit 5 of col set means negative (or past any valid column): always a collision.
    function automatic logic hits(input logic [7:0] mask, input logic signed [5:0] col,
                                  input logic [COLS-1:0] row_a, input logic [COLS-1:0] row_b);
        logic [COLS+3:0] wa, wb;
        wa = {{COLS{1'b0}}, mask[3:0]} << col[4:0];
        wb = {{COLS{1'b0}}, mask[7:4]} << col[4:0];
        return col[5] | (|wa[COLS+3:COLS]) | (|wb[COLS+3:COLS])
             | (|(wa[COLS-1:0] & row_a)) | (|(wb[COLS-1:0] & row_b));
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cx_d      = cx_q;
        mask_d    = mask_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rp_d      = rp_q;
        wp_d      = wp_q;
        clr_d     = clr_q;
        lines_d   = lines_q;
        over_d    = over_q;
        locked_d  = 1'b0;
        clr_nx    = clr_q;
        rd_addr   = y_q[3:0];
        wr_en_raw = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
`ifdef SCORE_EN
        score_d   = score_q;
        score_sum = '0;
`endif
        unique case (state_q)
            S_INIT: begin
                wr_en_raw = 1'b1;
                wr_addr   = rp_q;
                rp_d      = rp_q + 4'd1;
                if (rp_q == LAST_ROW) state_d = S_SPAWN;
            end
            S_SPAWN: begin
                mask_d  = piece_mask;
                x_d     = SPAWN_X5;
                y_d     = '0;
                rd_addr = 4'd0;
                state_d = S_SP_RD;
            end
            S_SP_RD: begin
                rd_addr = 4'd1;
                ra_d    = rd_data;
                state_d = S_SP_CHK;
            end
            S_SP_CHK: begin
                if (hits(mask_q, {1'b0, x_q}, ra_q, rd_data)) begin
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (tick) begin
                    if (move_left && !move_right)      cx_d = {1'b0, x_q} - 6'sd1;
                    else if (move_right && !move_left) cx_d = {1'b0, x_q} + 6'sd1;
                    else                               cx_d = {1'b0, x_q};
                    state_d = S_HM_RD;
                end
            end
            S_HM_RD: begin
                rd_addr = y_q[3:0] + 4'd1;
                ra_d    = rd_data;
                state_d = S_HM_CHK;
            end
            S_HM_CHK: begin
                rb_d    = rd_data;
                rd_addr = y_q[3:0] + 4'd2;
                if (!hits(mask_q, cx_q, ra_q, rd_data)) x_d = cx_q[4:0];
                state_d = S_VC_CHK;
            end
            S_VC_CHK: begin
                if (y_q >= 5'(ROWS - 2) || hits(mask_q, {1'b0, x_q}, rb_q, rd_data)) begin
                    state_d = S_LOCK_A;
                end else begin
                    y_d     = y_q + 5'd1;
                    state_d = S_IDLE;
                end
            end
            S_LOCK_A: begin
                wr_en_raw = 1'b1;
                wr_addr   = y_q[3:0];
                wr_data   = ra_q | place(mask_q[3:0], x_q);
                state_d   = S_LOCK_B;
            end
            S_LOCK_B: begin
                wr_en_raw = 1'b1;
                wr_addr   = y_q[3:0] + 4'd1;
                wr_data   = rb_q | place(mask_q[7:4], x_q);
                locked_d  = 1'b1;
                rp_d      = LAST_ROW;
                wp_d      = 5'(ROWS - 1);
                clr_d     = '0;
                state_d   = S_CP_RD;
            end
            S_CP_RD: begin
                rd_addr = rp_q;
                state_d = S_CP_EV;
            end
            S_CP_EV: begin
                // Writes land on wp >= rp while later reads go strictly above rp, so no hazard.
                if (rd_data == FULL_ROW) begin
                    if (clr_q != 2'd3) clr_nx = clr_q + 2'd1;
                end else begin
                    wr_en_raw = 1'b1;
                    wr_addr   = wp_q[3:0];
                    wr_data   = rd_data;
                    wp_d      = wp_q - 5'd1;
                end
                clr_d = clr_nx;
                if (rp_q == 4'd0) begin
                    lines_d = clr_nx;
`ifdef SCORE_EN
                    score_sum = {1'b0, score_q} + ((clr_nx == 2'd0) ? 17'd0 :
                                                   (clr_nx == 2'd1) ? 17'd1 : 17'd3);
                    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    state_d = S_CLR;
                end else begin
                    rp_d    = rp_q - 4'd1;
                    state_d = S_CP_RD;
                end
            end
            S_CLR: begin
                if (!wp_q[4]) begin
                    wr_en_raw = 1'b1;
                    wr_addr   = wp_q[3:0];
                    wp_d      = wp_q - 5'd1;
                end
                if (wp_q[4] || wp_q == 5'd0) state_d = S_SPAWN;
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_INIT;
        endcase
    end

    // Gating with reset keeps an aborted operation from committing a write in the reset cycle.
    assign wr_en         = wr_en_raw & ~reset;
    assign piece_x       = x_q;
    assign piece_y       = y_q;
    assign busy          = (state_q != S_IDLE);
    assign locked        = locked_q;
    assign lines_cleared = lines_q;
    assign game_over     = over_q;
`ifdef SCORE_EN
    assign score         = score_q;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (reset) begin
            state_q  <= S_INIT;
            x_q      <= SPAWN_X5;
            y_q      <= '0;
            cx_q     <= '0;
            mask_q   <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rp_q     <= '0;
            wp_q     <= '0;
            clr_q    <= '0;
            lines_q  <= '0;
            locked_q <= 1'b0;
            over_q   <= 1'b0;
`ifdef SCORE_EN
            score_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cx_q     <= cx_d;
            mask_q   <= mask_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rp_q     <= rp_d;
            wp_q     <= wp_d;
            clr_q    <= clr_d;
            lines_q  <= lines_d;
            locked_q <= locked_d;
            over_q   <= over_d;
`ifdef SCORE_EN
            score_q  <= score_d;
`endif
        end
    end

endmodule

// File: tb/tb_grid_step_sequencer.sv
// Bench for grid_step_sequencer: owns a 1-cycle-latency grid RAM model and checks piece motion,
// locking, compaction, game over and reset abort. Score checks compile in when SCORE_EN is defined.
module tb_grid_step_sequencer;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tick = 1'b0;
    logic            move_left = 1'b0;
    logic            move_right = 1'b0;
    logic [7:0]      piece_mask = 8'h0F;
    logic [3:0]      rd_addr, wr_addr;
    logic [COLS-1:0] rd_data, wr_data;
    logic            wr_en;
    logic [4:0]      piece_x, piece_y;
    logic            busy, locked, game_over;
    logic [1:0]      lines_cleared;
`ifdef SCORE_EN
    logic [15:0]     score;
`endif

    always #5 clk = ~clk;

    grid_step_sequencer dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .move_left(move_left),
        .move_right(move_right),
        .piece_mask(piece_mask),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .piece_x(piece_x),
        .piece_y(piece_y),
        .busy(busy),
        .locked(locked),
        .lines_cleared(lines_cleared),
        .game_over(game_over)
`ifdef SCORE_EN
        , .score(score)
`endif
    );

    // Grid RAM model; the bench can preload rows through the poke port while the DUT is idle.
    logic [COLS-1:0] mem [ROWS] = '{default: 16'hA5A5};
    logic            poke_en = 1'b0;
    logic [3:0]      poke_addr = '0;
    logic [COLS-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (wr_en)        mem[wr_addr]   <= wr_data;
        else if (poke_en) mem[poke_addr] <= poke_data;
        rd_data <= mem[rd_addr];
    end

    int wr_count = 0;
    int lock_count = 0;
    always @(posedge clk) begin
        if (wr_en === 1'b1)  wr_count++;
        if (locked === 1'b1) lock_count++;
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic [4:0] x; logic [4:0] y;} exp_t;
    typedef struct packed {logic l; logic r; logic [4:0] x; logic [4:0] y;} vec_t;
    exp_t sb_q[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nonzero_rows();
        int n = 0;
        for (int i = 0; i < ROWS; i++) if (mem[i] !== '0) n++;
        return n;
    endfunction

    task automatic poke(input logic [3:0] a, input logic [COLS-1:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic do_tick(input logic l, input logic r);
        @(negedge clk);
        tick = 1'b1; move_left = l; move_right = r;
        @(negedge clk);
        tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int cyc = 0;
        while (busy !== 1'b0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " idle"}, busy, 0);
    endtask

    // Latency counted from the tick cycle to the first cycle back in IDLE.
    task automatic tick_and_wait(input logic l, input logic r, input int limit, input string name);
        int cyc = 1;
        do_tick(l, r);
        while (busy !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " idle"}, busy, 0);
        check({name, " latency"}, (cyc <= limit), 1);
    endtask

    task automatic step(input logic l, input logic r, input logic [4:0] ex, input logic [4:0] ey,
                        input string name);
        exp_t e;
        sb_q.push_back('{x: ex, y: ey});
        tick_and_wait(l, r, 8, name);
        e = sb_q.pop_front();
        check({name, " x"}, piece_x, e.x);
        check({name, " y"}, piece_y, e.y);
    endtask

    task automatic drop_steps(input int n, input logic [4:0] x, input string tag);
        for (int i = 1; i <= n; i++) step(1'b0, 1'b0, x, 5'(i), $sformatf("%s%0d", tag, i));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int lk;
        int cyc;

        // Left-edge walk, both keys, then right moves; starts at x=6, y=0 with mask 0F.
        vecs[0]  = '{1'b1, 1'b0, 5'd5, 5'd1};
        vecs[1]  = '{1'b1, 1'b0, 5'd4, 5'd2};
        vecs[2]  = '{1'b1, 1'b0, 5'd3, 5'd3};
        vecs[3]  = '{1'b1, 1'b0, 5'd2, 5'd4};
        vecs[4]  = '{1'b1, 1'b0, 5'd1, 5'd5};
        vecs[5]  = '{1'b1, 1'b0, 5'd0, 5'd6};
        vecs[6]  = '{1'b1, 1'b0, 5'd0, 5'd7};
        vecs[7]  = '{1'b1, 1'b0, 5'd0, 5'd8};
        vecs[8]  = '{1'b1, 1'b1, 5'd0, 5'd9};
        vecs[9]  = '{1'b0, 1'b1, 5'd1, 5'd10};
        vecs[10] = '{1'b0, 1'b0, 5'd1, 5'd11};
        vecs[11] = '{1'b0, 1'b1, 5'd2, 5'd12};
        vecs[12] = '{1'b0, 1'b0, 5'd2, 5'd13};
        vecs[13] = '{1'b0, 1'b0, 5'd2, 5'd14};

        // Reset state and INIT clear.
        @(negedge clk);
        check("rst piece_x", piece_x, 6);
        check("rst piece_y", piece_y, 0);
        check("rst busy", busy, 1);
        check("rst locked", locked, 0);
        check("rst lines", lines_cleared, 0);
        check("rst game_over", game_over, 0);
        check("rst wr_en", wr_en, 0);
`ifdef SCORE_EN
        check("rst score", score, 0);
`endif
        reset = 1'b0;
        wait_idle(40, "init");
        check("init writes", wr_count, 16);
        check("init grid zero", nonzero_rows(), 0);
        check("init piece_x", piece_x, 6);
        check("init game_over", game_over, 0);

        // Straight drop of mask 0F: top row lands on row 14.
        drop_steps(14, 5'd6, "drop0f_");
        lk = lock_count;
        tick_and_wait(1'b0, 1'b0, 47, "lock1");
        check("lock1 pulses", lock_count - lk, 1);
        check("lock1 row14", mem[14], 16'h03C0);
        check("lock1 row15", mem[15], 16'h0000);
        check("lock1 lines", lines_cleared, 0);
        check("lock1 respawn x", piece_x, 6);
        check("lock1 respawn y", piece_y, 0);

        // Table-driven horizontal moves while descending.
        for (int i = 0; i < 14; i++)
            step(vecs[i].l, vecs[i].r, vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
        piece_mask = 8'hF0;
        tick_and_wait(1'b0, 1'b0, 47, "lock2");
        check("lock2 row14", mem[14], 16'h03FC);
        check("lock2 row15", mem[15], 16'h0000);

        // One full row cleared; rows above shift down by one.
        poke(4'd13, 16'h8001);
        poke(4'd14, 16'h0000);
        poke(4'd15, 16'hFC3F);
        drop_steps(14, 5'd6, "dropf0_");
        piece_mask = 8'hFF;
        tick_and_wait(1'b0, 1'b0, 47, "lock3");
        check("lock3 lines", lines_cleared, 1);
        check("lock3 row15", mem[15], 16'h0000);
        check("lock3 row14", mem[14], 16'h8001);
        check("lock3 row13", mem[13], 16'h0000);
`ifdef SCORE_EN
        check("lock3 score", score, 1);
`endif

        // Two full rows cleared.
        poke(4'd12, 16'h4002);
        poke(4'd14, 16'hFC3F);
        poke(4'd15, 16'hFC3F);
        drop_steps(14, 5'd6, "dropff_");
        check("held lines", lines_cleared, 1);
        tick_and_wait(1'b0, 1'b0, 47, "lock4");
        check("lock4 lines", lines_cleared, 2);
        check("lock4 row15", mem[15], 16'h0000);
        check("lock4 row14", mem[14], 16'h4002);
        check("lock4 row12", mem[12], 16'h0000);
`ifdef SCORE_EN
        check("lock4 score", score, 4);
`endif

        // Lock at the top so the respawn is blocked.
        poke(4'd2, 16'h03C0);
        lk = lock_count;
        do_tick(1'b0, 1'b0);
        cyc = 0;
        while (game_over !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("over flag", game_over, 1);
        check("over busy", busy, 1);
        check("over lock pulse", lock_count - lk, 1);
        check("over lines", lines_cleared, 0);
        check("over row0", mem[0], 16'h03C0);
        check("over row1", mem[1], 16'h03C0);
        base = wr_count;
        for (int i = 0; i < 3; i++) begin
            do_tick(1'b0, 1'b1);
            repeat (10) @(negedge clk);
        end
        check("over no writes", wr_count - base, 0);
        check("over sticky", game_over, 1);
        check("over piece_y", piece_y, 0);

        // Reset out of game over; a tick during INIT is dropped.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("rst2 game_over", game_over, 0);
        wait_idle(40, "init2");
        repeat (10) @(negedge clk);
        check("dropped tick y", piece_y, 0);
        check("dropped tick busy", busy, 0);
        check("init2 grid zero", nonzero_rows(), 0);

        // Reset in the middle of compaction, on a cycle that would write.
        poke(4'd2, 16'h03C0);
        do_tick(1'b0, 1'b0);
        cyc = 0;
        while (locked !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("cp lock seen", locked, 1);
        cyc = 0;
        while (wr_en !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("cp write seen", wr_en, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("cp reset wr_en", wr_en, 0);
        base = wr_count;
        @(negedge clk);
        reset = 1'b0;
        wait_idle(40, "init3");
        check("init3 writes", wr_count - base, 16);
        check("init3 grid zero", nonzero_rows(), 0);
        check("init3 locked", locked, 0);
        check("init3 lines", lines_cleared, 0);
`ifdef SCORE_EN
        check("init3 score", score, 0);
`endif
        check("scoreboard empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
